// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the hazard scheduler: FSM state and register-index constants.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// CNT_W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: memory-wait freeze, branch flush, load-use stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_useRs1,
  input  logic             id_useRs2,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branchTaken,
  input  logic             mem_memRead,
  input  logic             mem_memWrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;

  logic pending, stalled, freeze, loaduse;
  logic sel_freeze, sel_branch, sel_loaduse;

  assign pending = mem_memRead | mem_memWrite;
  assign stalled = pending & ~dmem_ready;
  assign freeze  = stalled & (wait_cnt_q < TIMEOUT_V);
  assign loaduse = ex_memRead & (ex_rd != ZERO_REG) &
                   ((id_useRs1 & (id_rs1 == ex_rd)) | (id_useRs2 & (id_rs2 == ex_rd)));

  // Reset masks every hazard so the pipeline sees plain "advance" while rst is high.
  assign sel_freeze  = ~rst & freeze;
  assign sel_branch  = ~rst & ~freeze & ex_branchTaken;
  assign sel_loaduse = ~rst & ~freeze & ~ex_branchTaken & loaduse;

  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (sel_freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (sel_branch) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (sel_loaduse) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      RUN: begin
        if (stalled) begin
          state_d    = WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (!stalled) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < TIMEOUT_V) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          // Access abandoned: the pipeline moves on with whatever data MEM holds.
          state_d       = RUN;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_loaduse (
    .clk(clk), .rst(rst), .inc(sel_loaduse), .cnt(cnt_loaduse)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk(clk), .rst(rst), .inc(sel_branch), .cnt(cnt_flush)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_freeze (
    .clk(clk), .rst(rst), .inc(sel_freeze), .cnt(cnt_freeze)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a 16-bit-counter instance plus a 2-bit-counter twin for saturation.
module tb_hazard_ctrl;
  localparam int TO = 4;

  // {pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
  localparam logic [7:0] CTL_NORM = 8'b1010_1010;
  localparam logic [7:0] CTL_FRZ  = 8'b0000_0001;
  localparam logic [7:0] CTL_BR   = 8'b1111_1110;
  localparam logic [7:0] CTL_LU   = 8'b0000_1110;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_useRs1, id_useRs2, ex_memRead, ex_branchTaken;
  logic       mem_memRead, mem_memWrite, dmem_ready;

  logic        pc_write, pc_sel_branch, if_id_write, if_id_flush;
  logic        id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_timeout;
  logic [15:0] cnt_loaduse, cnt_flush, cnt_freeze;

  logic        s_pc_write, s_pc_sel_branch, s_if_id_write, s_if_id_flush;
  logic        s_id_ex_write, s_id_ex_bubble, s_ex_mem_write, s_mem_wb_bubble, s_mem_timeout;
  logic [1:0]  s_cnt_loaduse, s_cnt_flush, s_cnt_freeze;

  logic [7:0] ctl;
  assign ctl = {pc_write, pc_sel_branch, if_id_write, if_id_flush,
                id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .ex_branchTaken(ex_branchTaken),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout(mem_timeout),
    .cnt_loaduse(cnt_loaduse), .cnt_flush(cnt_flush), .cnt_freeze(cnt_freeze)
  );

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .ex_branchTaken(ex_branchTaken),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .dmem_ready(dmem_ready),
    .pc_write(s_pc_write), .pc_sel_branch(s_pc_sel_branch),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_write(s_id_ex_write), .id_ex_bubble(s_id_ex_bubble),
    .ex_mem_write(s_ex_mem_write), .mem_wb_bubble(s_mem_wb_bubble),
    .mem_timeout(s_mem_timeout),
    .cnt_loaduse(s_cnt_loaduse), .cnt_flush(s_cnt_flush), .cnt_freeze(s_cnt_freeze)
  );

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_useRs1 = 1'b0; id_useRs2 = 1'b0; ex_memRead = 1'b0; ex_branchTaken = 1'b0;
    mem_memRead = 1'b0; mem_memWrite = 1'b0; dmem_ready = 1'b0;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    mem_memRead = 1'b1; ex_branchTaken = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd3;
    id_rs1 = 5'd3; id_useRs1 = 1'b1;
    step(); step();
    checks++;
    if (ctl !== CTL_NORM) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_NORM); end
    checks++;
    if ({mem_timeout, cnt_loaduse, cnt_flush, cnt_freeze} !== 49'd0) begin
      errors++; $display("FAIL reset_state: timeout=%b lu=%0d fl=%0d fr=%0d want all 0",
                         mem_timeout, cnt_loaduse, cnt_flush, cnt_freeze);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_NORM) begin errors++; $display("FAIL idle_ctl: got %b want %b", ctl, CTL_NORM); end
  endtask

  task automatic test_loaduse();
    @(negedge clk);
    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_useRs1 = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL loaduse_ctl: got %b want %b", ctl, CTL_LU); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cnt_loaduse !== 16'd1) begin errors++; $display("FAIL loaduse_cnt: got %0d want 1", cnt_loaduse); end
    // rs2 match path
    @(negedge clk);
    ex_memRead = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_useRs2 = 1'b1; id_rs1 = 5'd9;
    #1;
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL loaduse_rs2_ctl: got %b want %b", ctl, CTL_LU); end
    // x0 destination never stalls
    @(negedge clk);
    ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_useRs1 = 1'b1; id_rs2 = 5'd0; id_useRs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_NORM) begin errors++; $display("FAIL loaduse_x0_ctl: got %b want %b", ctl, CTL_NORM); end
    // match without a use flag is not a hazard
    @(negedge clk);
    ex_memRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_useRs1 = 1'b0; id_rs2 = 5'd0; id_useRs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_NORM) begin errors++; $display("FAIL loaduse_nouse_ctl: got %b want %b", ctl, CTL_NORM); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cnt_loaduse !== 16'd2) begin errors++; $display("FAIL loaduse_cnt2: got %0d want 2", cnt_loaduse); end
  endtask

  task automatic test_branch_loaduse();
    @(negedge clk);
    ex_branchTaken = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_useRs1 = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL branch_ctl: got %b want %b", ctl, CTL_BR); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({cnt_flush, cnt_loaduse} !== {16'd1, 16'd2}) begin
      errors++; $display("FAIL branch_cnt: flush=%0d lu=%0d want 1 2", cnt_flush, cnt_loaduse);
    end
  endtask

  task automatic test_mem_wait();
    @(negedge clk);
    mem_memRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_FRZ) begin errors++; $display("FAIL memwait_frz[%0d]: got %b want %b", i, ctl, CTL_FRZ); end
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_NORM) begin errors++; $display("FAIL memwait_release: got %b want %b", ctl, CTL_NORM); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cnt_freeze !== 16'd3) begin errors++; $display("FAIL memwait_cnt: got %0d want 3", cnt_freeze); end
  endtask

  task automatic test_freeze_branch();
    @(negedge clk);
    mem_memRead = 1'b1; dmem_ready = 1'b0; ex_branchTaken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_FRZ) begin errors++; $display("FAIL frzbr_hold[%0d]: got %b want %b", i, ctl, CTL_FRZ); end
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_BR) begin errors++; $display("FAIL frzbr_flush: got %b want %b", ctl, CTL_BR); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({cnt_freeze, cnt_flush} !== {16'd5, 16'd2}) begin
      errors++; $display("FAIL frzbr_cnt: freeze=%0d flush=%0d want 5 2", cnt_freeze, cnt_flush);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    mem_memWrite = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_FRZ) begin errors++; $display("FAIL timeout_frz[%0d]: got %b want %b", i, ctl, CTL_FRZ); end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({ctl, mem_timeout} !== {CTL_NORM, 1'b0}) begin
      errors++; $display("FAIL timeout_release: ctl=%b to=%b want %b 0", ctl, mem_timeout, CTL_NORM);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", mem_timeout); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({mem_timeout, cnt_freeze} !== {1'b1, 16'd9}) begin
      errors++; $display("FAIL timeout_sticky: to=%b freeze=%0d want 1 9", mem_timeout, cnt_freeze);
    end
  endtask

  task automatic test_reset_mid_wait();
    // 3 frozen, 1 released, then 4 frozen: left in WAIT with wait_cnt at the limit
    @(negedge clk);
    mem_memRead = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (cnt_freeze !== 16'd16) begin errors++; $display("FAIL midwait_pre: freeze=%0d want 16", cnt_freeze); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ctl, mem_timeout, cnt_loaduse, cnt_flush, cnt_freeze} !== {CTL_NORM, 49'd0}) begin
      errors++; $display("FAIL midwait_rst: ctl=%b to=%b lu=%0d fl=%0d fr=%0d want %b 0 0 0 0",
                         ctl, mem_timeout, cnt_loaduse, cnt_flush, cnt_freeze, CTL_NORM);
    end
    // Released with the access still stalled: a full fresh TO-cycle freeze proves wait_cnt was cleared.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_FRZ) begin errors++; $display("FAIL midwait_refrz[%0d]: got %b want %b", i, ctl, CTL_FRZ); end
      @(negedge clk);
    end
    #1;
    checks++;
    if (ctl !== CTL_NORM) begin errors++; $display("FAIL midwait_unfrz: got %b want %b", ctl, CTL_NORM); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_saturate();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_memRead = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; id_useRs2 = 1'b1;
    repeat (5) @(negedge clk);
    idle();
    #1;
    checks++;
    if (s_cnt_loaduse !== 2'd3) begin errors++; $display("FAIL sat_small: got %0d want 3", s_cnt_loaduse); end
    checks++;
    if (cnt_loaduse !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d want 5", cnt_loaduse); end
    @(negedge clk);
    #1;
    checks++;
    if (s_cnt_loaduse !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d want 3", s_cnt_loaduse); end
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_branch_loaduse();
    test_mem_wait();
    test_freeze_branch();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
